// File: rtl/vl_strip_sequencer.sv
// Strip-mining sequencer: walks AVL in strips of at most VLMAX elements.
// VL_STRIP_BACK2BACK_EN removes the SETUP bubble between consecutive strips.
module vl_strip_sequencer #(
  parameter int VLEN = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] sew,
  input  logic [4:0] lmul,
  input  logic [8:0] avl,
  output logic       busy,
  output logic       strip_start,
  output logic [8:0] vl_out,
  output logic       elem_valid,
  input  logic       elem_ready,
  output logic [8:0] elem_idx,
  output logic       elem_last,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ISSUE,
    DONE
  } state_t;

  state_t     state;
  logic [8:0] rem;
  logic [2:0] sew_sh;
  logic [2:0] lmul_sh;
  logic [2:0] sew_dec;
  logic [2:0] lmul_dec;
  logic       sew_ok;
  logic       lmul_ok;
  logic [9:0] vlmax;
  logic [8:0] nvl;
  logic       hs;

  always_comb begin
    sew_ok  = 1'b1;
    sew_dec = 3'd3;
    unique case (sew)
      8'd8:    sew_dec = 3'd3;
      8'd16:   sew_dec = 3'd4;
      8'd32:   sew_dec = 3'd5;
      8'd64:   sew_dec = 3'd6;
      8'd128:  sew_dec = 3'd7;
      default: sew_ok  = 1'b0;
    endcase
  end

  always_comb begin
    lmul_ok  = 1'b1;
    lmul_dec = 3'd0;
    unique case (lmul)
      5'd1:    lmul_dec = 3'd0;
      5'd2:    lmul_dec = 3'd1;
      5'd4:    lmul_dec = 3'd2;
      5'd8:    lmul_dec = 3'd3;
      5'd16:   lmul_dec = 3'd4;
      default: lmul_ok  = 1'b0;
    endcase
  end

  // vlmax from the latched log2 shifts, so it is stable for the sequence
  assign vlmax = 10'((VLEN >> sew_sh) << lmul_sh);
  assign nvl   = ({1'b0, rem} < vlmax) ? rem : vlmax[8:0];
  assign hs    = elem_valid & elem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      sew_sh      <= 3'd3;
      lmul_sh     <= 3'd0;
      busy        <= 1'b0;
      strip_start <= 1'b0;
      vl_out      <= '0;
      elem_valid  <= 1'b0;
      elem_idx    <= '0;
      elem_last   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      strip_start <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rem     <= avl;
            sew_sh  <= sew_dec;
            lmul_sh <= lmul_dec;
            if (!(sew_ok && lmul_ok)) begin
              err <= 1'b1;
            end else if (avl == 9'd0) begin
              busy  <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          vl_out      <= nvl;
          rem         <= rem - nvl;
          elem_idx    <= '0;
          elem_valid  <= 1'b1;
          strip_start <= 1'b1;
          elem_last   <= (nvl == 9'd1);
          state       <= ISSUE;
        end
        ISSUE: begin
          if (hs) begin
            if (!elem_last) begin
              elem_idx  <= elem_idx + 9'd1;
              elem_last <= (elem_idx + 9'd1 == vl_out - 9'd1);
            end else if (rem == 9'd0) begin
              elem_valid <= 1'b0;
              elem_last  <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
`ifdef VL_STRIP_BACK2BACK_EN
              vl_out      <= nvl;
              rem         <= rem - nvl;
              elem_idx    <= '0;
              strip_start <= 1'b1;
              elem_last   <= (nvl == 9'd1);
`else
              elem_valid  <= 1'b0;
              elem_last   <= 1'b0;
              state       <= SETUP;
`endif
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vl_strip_sequencer.sv
// Randomized bench for vl_strip_sequencer against a strip-list model.
// Honors VL_STRIP_BACK2BACK_EN for the expected completion cycle.
module tb_vl_strip_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] sew;
  logic [4:0] lmul;
  logic [8:0] avl;
  logic       elem_ready;
  logic       busy;
  logic       strip_start;
  logic [8:0] vl_out;
  logic       elem_valid;
  logic [8:0] elem_idx;
  logic       elem_last;
  logic       done;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;
  int vls[$];

  vl_strip_sequencer #(.VLEN(128)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sew(sew),
    .lmul(lmul),
    .avl(avl),
    .busy(busy),
    .strip_start(strip_start),
    .vl_out(vl_out),
    .elem_valid(elem_valid),
    .elem_ready(elem_ready),
    .elem_idx(elem_idx),
    .elem_last(elem_last),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return ((c % 4) == 0) || ((c % 4) == 3);
    endcase
  endfunction

  function automatic int all_outs();
    return int'({busy, strip_start, elem_valid, elem_last,
                 done, err, vl_out, elem_idx});
  endfunction

  task automatic run_seq(input int s, input int l, input int a,
                         input int mode, input bit again,
                         input int rst_at);
    int  vmax, r, strip, idx, hs, lasts, dones, errs;
    int  done_c, exp_done, c, prev_idx, cur;
    bit  ok, stalled;
    ok = (s inside {8, 16, 32, 64, 128}) &&
         (l inside {1, 2, 4, 8, 16});
    vls.delete();
    strip = 0; idx = 0; hs = 0; lasts = 0;
    dones = 0; errs = 0; done_c = -1;
    stalled = 0; prev_idx = 0;
    if (ok) begin
      vmax = (128 / s) * l;
      r = a;
      while (r > 0) begin
        vls.push_back(r < vmax ? r : vmax);
        r -= vls[$];
      end
    end
    if (!ok) exp_done = -1;
    else if (a == 0) exp_done = 1;
    else
`ifdef VL_STRIP_BACK2BACK_EN
      exp_done = a + 2;
`else
      exp_done = a + 1 + vls.size();
`endif

    @(negedge clk);
    sew = 8'(s); lmul = 5'(l); avl = 9'(a);
    start = 1'b1; elem_ready = 1'b0;
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      start = again && (c == 3);
      if (start) begin
        sew = 8'd8; lmul = 5'd1; avl = 9'd7;
      end
      if (err) errs++;
      if (done) begin
        dones++;
        done_c = c;
      end
      check("err", int'(err), int'(!ok && c == 1));
      if (!ok) check("busy_err", int'(busy), 0);
      else if (done_c < 0 || c == done_c) check("busy", int'(busy), 1);
      else check("busy_idle", int'(busy), 0);

      if (strip_start) begin
        if (strip >= vls.size()) begin
          check("ss_extra", strip, vls.size());
        end else begin
          check("ss_vl", int'(vl_out), vls[strip]);
          check("ss_idx", int'(elem_idx), 0);
          check("ss_valid", int'(elem_valid), 1);
        end
        strip++;
        idx = 0;
      end
      if (stalled)
        check("hold", int'({elem_valid, elem_idx}),
              int'({1'b1, 9'(prev_idx)}));

      if (rst_at == c) begin
        rst = 1'b1;
        #1;
        check("rst_outs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b0; elem_ready = 1'b0;
        @(negedge clk);
        check("rst_idle", int'({busy, done, err}), 0);
        return;
      end

      elem_ready = pick_ready(mode, c);
      stalled = elem_valid && !elem_ready;
      prev_idx = int'(elem_idx);
      if (!elem_valid) begin
        check("last_q", int'(elem_last), 0);
      end else if (elem_ready) begin
        if (strip == 0 || strip > vls.size()) begin
          check("hs_strip", strip, (strip == 0) ? 1 : vls.size());
        end else begin
          cur = vls[strip-1];
          check("idx", int'(elem_idx), idx);
          check("last", int'(elem_last), int'(idx == cur - 1));
          check("vl", int'(vl_out), cur);
        end
        if (elem_last) lasts++;
        idx++;
        hs++;
      end

      if (ok && done_c > 0 && c >= done_c + 2) break;
      if (!ok && c >= 4) break;
      if (c >= 3000) begin
        check("timeout", c, exp_done);
        break;
      end
    end
    start = 1'b0;
    elem_ready = 1'b0;
    check("dones", dones, ok ? 1 : 0);
    check("errs", errs, ok ? 0 : 1);
    check("strips", strip, vls.size());
    check("hs", hs, ok ? a : 0);
    check("lasts", lasts, vls.size());
    if (ok && mode == 0) check("done_cyc", done_c, exp_done);
  endtask

  initial begin
    int sl[5];
    int ll[5];
    int s, l, a;
    sl = '{8, 16, 32, 64, 128};
    ll = '{1, 2, 4, 8, 16};
    rst = 1'b1; start = 1'b0; sew = '0; lmul = '0;
    avl = '0; elem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", all_outs(), 0);

    run_seq(32, 1, 10, 0, 1'b0, 0);
    run_seq(8, 16, 300, 1, 1'b0, 0);
    run_seq(8, 16, 300, 0, 1'b0, 0);
    run_seq(24, 1, 5, 0, 1'b0, 0);
    run_seq(32, 3, 5, 0, 1'b0, 0);
    run_seq(16, 2, 0, 0, 1'b0, 0);
    run_seq(64, 4, 20, 2, 1'b1, 0);
    run_seq(32, 1, 10, 2, 1'b0, 5);
    run_seq(128, 1, 3, 0, 1'b0, 0);

    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    sew = 8'd32; lmul = 5'd1; avl = 9'd5;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    check("start_at_rst", int'({busy, elem_valid, done}), 0);

    for (int i = 0; i < 20; i++) begin
      s = sl[$urandom_range(0, 4)];
      l = ll[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) s = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) l = $urandom_range(0, 31);
      a = $urandom_range(0, 511);
      run_seq(s, l, a, $urandom_range(0, 2),
              1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
